// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ack check.
// Both lines are open-drain; the device clock is deglitched before use.
module ps2_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);
    localparam int RW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CW = (RW > TW) ? RW : TW;
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, RTS, START, DATA, STOP, ACK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    filt_q, filt_d;
    logic          fval_q, fval_d;
    logic          fall_edge;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          c_low, d_low;

    // filtered clock only changes once all eight samples agree
    assign filt_d    = {ps2c, filt_q[7:1]};
    assign fval_d    = (filt_q == 8'hFF) ? 1'b1 :
                       (filt_q == 8'h00) ? 1'b0 : fval_q;
    assign fall_edge = fval_q & ~fval_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            filt_q  <= 8'hFF;
            fval_q  <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            fval_q  <= fval_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ps2 && !done_q) begin
                    shift_d = {~^din, din};
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end
            RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START, DATA, STOP, ACK: begin
                if (fall_edge) begin
                    cnt_d = '0;
                    case (state_q)
                        START: begin
                            bit_d   = 4'd8;
                            state_d = DATA;
                        end
                        DATA: begin
                            shift_d = {1'b0, shift_q[8:1]};
                            if (bit_q == 4'd0) state_d = STOP;
                            else bit_d = bit_q - 1'b1;
                        end
                        STOP: state_d = ACK;
                        default: begin
                            err_d   = ps2d;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_idle = (state_q == IDLE);
        c_low   = (state_q == RTS);
        d_low   = 1'b0;
        case (state_q)
            START:   d_low = 1'b1;
            DATA:    d_low = ~shift_q[0];
            default: d_low = 1'b0;
        endcase
    end

    assign ps2c         = c_low ? 1'b0 : 1'bz;
    assign ps2d         = d_low ? 1'b0 : 1'bz;
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;
endmodule
